// File: rtl/car_detector.sv
// Two-beam car entry/exit detector: synchronizes the sensors and pulses in/out/err.
// Define DEBOUNCE_EN to insert a per-sensor debounce filter before the FSM.
module car_detector #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sens_a,
  input  logic sens_b,
  output logic in,
  output logic out,
  output logic err,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, ERR
  } state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_chk
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  state_t     state;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] ab;
  logic       run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      run   <= 1'b0;
    end else begin
      sync1 <= {sens_a, sens_b};
      sync2 <= sync1;
      run   <= 1'b1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    filt;
  logic [CW-1:0] cnt [2];

  // Accept a new level only after an unbroken run of matching samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign ab = filt;
`else
  assign ab = sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      in    <= 1'b0;
      out   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else if (run) begin
      in  <= 1'b0;
      out <= 1'b0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (ab)
            2'b00: ;
            2'b10: begin state <= IN_A;  busy <= 1'b1; end
            2'b01: begin state <= OUT_B; busy <= 1'b1; end
            default: begin
              state <= ERR; busy <= 1'b1; err <= 1'b1;
            end
          endcase
        end
        IN_A: begin
          unique case (ab)
            2'b10: ;
            2'b11: state <= IN_AB;
            2'b00: begin state <= IDLE; busy <= 1'b0; end
            default: begin state <= ERR; err <= 1'b1; end
          endcase
        end
        IN_AB: begin
          unique case (ab)
            2'b11: ;
            2'b01: state <= IN_B;
            2'b10: state <= IN_A;
            default: begin state <= ERR; err <= 1'b1; end
          endcase
        end
        IN_B: begin
          unique case (ab)
            2'b01: ;
            2'b00: begin
              state <= IDLE; busy <= 1'b0; in <= 1'b1;
            end
            2'b11: state <= IN_AB;
            default: begin state <= ERR; err <= 1'b1; end
          endcase
        end
        OUT_B: begin
          unique case (ab)
            2'b01: ;
            2'b11: state <= OUT_AB;
            2'b00: begin state <= IDLE; busy <= 1'b0; end
            default: begin state <= ERR; err <= 1'b1; end
          endcase
        end
        OUT_AB: begin
          unique case (ab)
            2'b11: ;
            2'b10: state <= OUT_A;
            2'b01: state <= OUT_B;
            default: begin state <= ERR; err <= 1'b1; end
          endcase
        end
        OUT_A: begin
          unique case (ab)
            2'b10: ;
            2'b00: begin
              state <= IDLE; busy <= 1'b0; out <= 1'b1;
            end
            2'b11: state <= OUT_AB;
            default: begin state <= ERR; err <= 1'b1; end
          endcase
        end
        default: begin
          if (ab == 2'b00) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_detector.sv
// Directed, table-driven bench for car_detector.
module tb_car_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic in, out, err, busy;

  int tests = 0;
  int fails = 0;

`ifdef DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  car_detector #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
    .in(in), .out(out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic [1:0] ab;
    int       hold;
    int       n_in;
    int       n_out;
    int       n_err;
    logic     busy;
  } vec_t;

  vec_t vt [$];

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(string n, logic [1:0] ab, int ni, int no,
                     int ne, logic bz);
    vec_t v;
    v.name = n; v.ab = ab; v.hold = LAT + 4;
    v.n_in = ni; v.n_out = no; v.n_err = ne; v.busy = bz;
    vt.push_back(v);
  endtask

  // Drive a pattern at a negedge and hold it, counting pulses.
  task automatic apply(logic [1:0] ab, int hold, output int ni,
                       output int no, output int ne, output int excl);
    ni = 0; no = 0; ne = 0; excl = 0;
    {sens_a, sens_b} = ab;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      ni += int'(in);
      no += int'(out);
      ne += int'(err);
      if (int'(in) + int'(out) + int'(err) > 1) excl++;
    end
  endtask

  task automatic step(logic [1:0] ab);
    int ni, no, ne, ex;
    apply(ab, LAT + 4, ni, no, ne, ex);
  endtask

  initial begin
    int ni, no, ne, ex, cnt;

    add("entry_10", 2'b10, 0, 0, 0, 1'b1);
    add("entry_11", 2'b11, 0, 0, 0, 1'b1);
    add("entry_01", 2'b01, 0, 0, 0, 1'b1);
    add("entry_00", 2'b00, 1, 0, 0, 1'b0);
    add("exit_01",  2'b01, 0, 0, 0, 1'b1);
    add("exit_11",  2'b11, 0, 0, 0, 1'b1);
    add("exit_10",  2'b10, 0, 0, 0, 1'b1);
    add("exit_00",  2'b00, 0, 1, 0, 1'b0);
    add("bk_10",    2'b10, 0, 0, 0, 1'b1);
    add("bk_11",    2'b11, 0, 0, 0, 1'b1);
    add("bk_10b",   2'b10, 0, 0, 0, 1'b1);
    add("bk_00",    2'b00, 0, 0, 0, 1'b0);
    add("obk_01",   2'b01, 0, 0, 0, 1'b1);
    add("obk_11",   2'b11, 0, 0, 0, 1'b1);
    add("obk_01b",  2'b01, 0, 0, 0, 1'b1);
    add("obk_00",   2'b00, 0, 0, 0, 1'b0);
    add("ill_11",   2'b11, 0, 0, 1, 1'b1);
    add("ill_11h",  2'b11, 0, 0, 0, 1'b1);
    add("ill_10h",  2'b10, 0, 0, 0, 1'b1);
    add("ill_00",   2'b00, 0, 0, 0, 1'b0);
    add("swap_10",  2'b10, 0, 0, 0, 1'b1);
    add("swap_01",  2'b01, 0, 0, 1, 1'b1);
    add("swap_00",  2'b00, 0, 0, 0, 1'b0);
    add("rb_10",    2'b10, 0, 0, 0, 1'b1);
    add("rb_11",    2'b11, 0, 0, 0, 1'b1);
    add("rb_01",    2'b01, 0, 0, 0, 1'b1);
    add("rb_11b",   2'b11, 0, 0, 0, 1'b1);
    add("rb_01b",   2'b01, 0, 0, 0, 1'b1);
    add("rb_00",    2'b00, 1, 0, 0, 1'b0);
    add("xa_01",    2'b01, 0, 0, 0, 1'b1);
    add("xa_11",    2'b11, 0, 0, 0, 1'b1);
    add("xa_10",    2'b10, 0, 0, 0, 1'b1);
    add("xa_01",    2'b01, 0, 0, 1, 1'b1);
    add("xa_00",    2'b00, 0, 0, 0, 1'b0);

    // asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    check("rst_in",   int'(in),   0);
    check("rst_out",  int'(out),  0);
    check("rst_err",  int'(err),  0);
    check("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vt[i]) begin
      apply(vt[i].ab, vt[i].hold, ni, no, ne, ex);
      check({vt[i].name, "_in"},   ni, vt[i].n_in);
      check({vt[i].name, "_out"},  no, vt[i].n_out);
      check({vt[i].name, "_err"},  ne, vt[i].n_err);
      check({vt[i].name, "_busy"}, int'(busy), int'(vt[i].busy));
      check({vt[i].name, "_excl"}, ex, 0);
    end

    // exact pulse latency on the final entry edge
    step(2'b10);
    step(2'b11);
    step(2'b01);
    {sens_a, sens_b} = 2'b00;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat_in_e%0d", i), int'(in), int'(i == LAT));
      check($sformatf("lat_busy_e%0d", i), int'(busy), int'(i < LAT));
    end
    repeat (3) @(negedge clk);

    // busy rises exactly LAT edges after the exit pattern starts
    {sens_a, sens_b} = 2'b01;
    for (int i = 0; i <= LAT; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("xbusy_e%0d", i), int'(busy), int'(i == LAT));
    end
    step(2'b00);
    check("xbusy_idle", int'(busy), 0);

    // reset mid-entry discards the sequence
    step(2'b10);
    step(2'b11);
    check("mid_busy_pre", int'(busy), 1);
    #3 reset = 1'b0;
    #1;
    check("mid_busy_rst", int'(busy), 0);
    check("mid_in_rst",   int'(in),   0);
    check("mid_out_rst",  int'(out),  0);
    check("mid_err_rst",  int'(err),  0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    {sens_a, sens_b} = 2'b00;
    reset = 1'b1;
    apply(2'b00, LAT + 8, ni, no, ne, ex);
    check("mid_no_in",  ni, 0);
    check("mid_no_err", ne, 0);
    check("mid_busy",   int'(busy), 0);

    // a pattern already present at release starts a fresh sequence
    reset = 1'b0;
    {sens_a, sens_b} = 2'b10;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    apply(2'b10, LAT + 6, ni, no, ne, ex);
    check("rel_busy", int'(busy), 1);
    check("rel_err",  ne, 0);
    step(2'b00);
    check("rel_idle", int'(busy), 0);

`ifdef DEBOUNCE_EN
    // a two-cycle glitch on sens_a is filtered out
    cnt = 0;
    sens_a = 1'b1;
    repeat (2) @(negedge clk);
    sens_a = 1'b0;
    repeat (12) begin
      @(negedge clk);
      cnt += int'(busy);
    end
    check("glitch_busy", cnt, 0);
`else
    cnt = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
